// File: rtl/bram_arb_wb.sv
// Two-master round-robin Wishbone arbiter in front of a single BRAM slave.
// One classic single-beat cycle at a time; a watchdog turns a missing slave ack into an error.
module bram_arb_wb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [29:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    output logic [31:0] m0_wb_dat_o,
    input  logic        m0_wb_we_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_cyc_i,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    input  logic [29:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    output logic [31:0] m1_wb_dat_o,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_cyc_i,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    output logic [29:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    input  logic [31:0] s_wb_dat_i,
    output logic        s_wb_we_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_cyc_o,
    output logic [3:0]  s_wb_sel_o,
    input  logic        s_wb_ack_i,
    output logic [1:0]  grant_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [1:0]    err_q, err_d;

    logic req0_s, req1_s, busy_s, own_cyc_s, own_stb_s, tcnt_done_s;

    assign req0_s      = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1_s      = m1_wb_cyc_i & m1_wb_stb_i;
    assign busy_s      = (state_q == BUSY);
    assign own_cyc_s   = owner_q ? m1_wb_cyc_i : m0_wb_cyc_i;
    assign own_stb_s   = owner_q ? m1_wb_stb_i : m0_wb_stb_i;
    assign tcnt_done_s = (tcnt_q == TW'(TIMEOUT - 1));

    // Arbitration and cycle-termination next state; a tie goes to whoever did not win last.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        err_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (req0_s && req1_s) begin
                    owner_d = ~last_q;
                    state_d = BUSY;
                    tcnt_d  = {TW{1'b0}};
                end else if (req0_s || req1_s) begin
                    owner_d = req1_s;
                    state_d = BUSY;
                    tcnt_d  = {TW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (s_wb_ack_i || !own_cyc_s) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (tcnt_done_s) begin
                    err_d   = owner_q ? 2'b10 : 2'b01;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    tcnt_d  = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last resets to 1 so m0 wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= {TW{1'b0}};
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

    // Bus routing: the owner sees the slave only while BUSY; late acks outside BUSY are dropped.
    always_comb begin
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_adr_o  = 30'h0;
        s_wb_dat_o  = 32'h0;
        s_wb_we_o   = 1'b0;
        s_wb_sel_o  = 4'h0;
        grant_o     = 2'b00;
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;
        m0_wb_dat_o = 32'h0;
        m1_wb_dat_o = 32'h0;
        if (busy_s) begin
            s_wb_cyc_o  = own_cyc_s;
            s_wb_stb_o  = own_stb_s;
            s_wb_adr_o  = owner_q ? m1_wb_adr_i : m0_wb_adr_i;
            s_wb_dat_o  = owner_q ? m1_wb_dat_i : m0_wb_dat_i;
            s_wb_we_o   = owner_q ? m1_wb_we_i  : m0_wb_we_i;
            s_wb_sel_o  = owner_q ? m1_wb_sel_i : m0_wb_sel_i;
            grant_o     = owner_q ? 2'b10 : 2'b01;
            m0_wb_ack_o = ~owner_q & s_wb_ack_i;
            m1_wb_ack_o = owner_q & s_wb_ack_i;
            m0_wb_dat_o = s_wb_dat_i;
            m1_wb_dat_o = s_wb_dat_i;
        end else begin
            grant_o     = 2'b00;
        end
    end

    assign m0_wb_err_o = err_q[0];
    assign m1_wb_err_o = err_q[1];

endmodule

// File: tb/tb_bram_arb_wb.sv
// Scoreboard bench for bram_arb_wb: two master drivers, a BRAM-style slave, and a per-master
// shadow memory plus a round-robin rule model that predict every grant, ack, error and read word.
module tb_bram_arb_wb;
    localparam int unsigned TO = 8;

    typedef struct packed {
        logic        is_err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    wire  [31:0] rdat0, rdat1;
    wire  [1:0]  ack_v, err_v;
    wire  [29:0] s_adr;
    wire  [31:0] s_dat;
    wire         s_we, s_stb, s_cyc;
    wire  [3:0]  s_sel;
    wire  [1:0]  grant_o;
    logic [31:0] s_rdat;
    logic        s_ack;
    logic        slave_dead;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    exp_t        exp0_q[$];
    exp_t        exp1_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    bram_arb_wb #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m0_wb_adr_i(m_adr[0]), .m0_wb_dat_i(m_dat[0]), .m0_wb_dat_o(rdat0),
        .m0_wb_we_i(m_we[0]), .m0_wb_sel_i(m_sel[0]), .m0_wb_stb_i(m_stb[0]),
        .m0_wb_cyc_i(m_cyc[0]), .m0_wb_ack_o(ack_v[0]), .m0_wb_err_o(err_v[0]),
        .m1_wb_adr_i(m_adr[1]), .m1_wb_dat_i(m_dat[1]), .m1_wb_dat_o(rdat1),
        .m1_wb_we_i(m_we[1]), .m1_wb_sel_i(m_sel[1]), .m1_wb_stb_i(m_stb[1]),
        .m1_wb_cyc_i(m_cyc[1]), .m1_wb_ack_o(ack_v[1]), .m1_wb_err_o(err_v[1]),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat), .s_wb_dat_i(s_rdat),
        .s_wb_we_o(s_we), .s_wb_stb_o(s_stb), .s_wb_cyc_o(s_cyc),
        .s_wb_sel_o(s_sel), .s_wb_ack_i(s_ack), .grant_o(grant_o)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = {16'hC0DE, 10'h0, 6'(i)};
        if (i == 16) w = 32'hDEADBEEF;
        return w;
    endfunction

    function automatic logic [29:0] rnd_adr(input int m);
        logic [29:0] r;
        r = 30'($urandom);
        r[5] = m[0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // BRAM-style slave: registered ack one cycle after stb, byte-lane writes.
    initial begin
        s_ack = 1'b0;
        s_rdat = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                s_ack <= 1'b0;
            end else if (s_stb && s_cyc && !s_ack && !slave_dead) begin
                if (s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) mem[s_adr[5:0]][8*b +: 8] <= s_dat[8*b +: 8];
                end
                s_rdat <= mem[s_adr[5:0]];
                s_ack  <= 1'b1;
            end else begin
                s_ack  <= 1'b0;
            end
        end
    end

    task automatic take_resp(input int m, input logic is_err, input logic [31:0] dat);
        exp_t e;
        int   sz;
        sz = (m == 0) ? exp0_q.size() : exp1_q.size();
        n_vec++;
        if (sz == 0) begin
            n_miss++;
            $display("FAIL m%0d_unexpected_resp: got err=%0b with nothing outstanding, expected no response", m, is_err);
        end else begin
            if (m == 0) e = exp0_q.pop_front();
            else        e = exp1_q.pop_front();
            chk($sformatf("m%0d_resp_is_err", m), {31'h0, is_err}, {31'h0, e.is_err});
            if (e.chk && !is_err) chk($sformatf("m%0d_rdata", m), dat, e.dat);
        end
    endtask

    // Issue one single-beat cycle; the shadow memory supplies the expected outcome.
    task automatic do_xfer(input int m, input logic we, input logic [29:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic exp_err, input int exp_lat);
        exp_t e;
        int   waited;
        logic got;
        e.is_err = exp_err;
        e.chk    = !we && !exp_err;
        e.dat    = ref_mem[adr[5:0]];
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[5:0]][8*b +: 8] = dat[8*b +: 8];
        if (m == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
        m_adr[m] = adr; m_dat[m] = dat; m_we[m] = we; m_sel[m] = sel;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 100) begin
            @(negedge clk);
            waited++;
            got = ack_v[m] | err_v[m];
        end
        n_vec++;
        if (!got) begin
            n_miss++;
            $display("FAIL m%0d_xfer_wait: got no ack/err within %0d cycles, expected a response", m, waited);
        end else if (exp_lat != 0) begin
            chk($sformatf("m%0d_latency", m), 32'(waited), 32'(exp_lat));
        end
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
    endtask

    // Monitor: response scoreboard, routing, and round-robin grant prediction.
    initial begin
        logic [1:0] prev_g, exp_g;
        logic [1:0] prev_req;
        logic       have_prev, last_w;
        int         cnt [2];
        int         o;
        have_prev = 1'b0; last_w = 1'b1; prev_g = 2'b00; prev_req = 2'b00;
        cnt[0] = 0; cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
                last_w = 1'b1;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    if (ack_v[m] || err_v[m])
                        chk($sformatf("m%0d_ack_err_exclusive", m), {31'h0, ack_v[m] & err_v[m]}, 32'h0);
                    if (ack_v[m]) begin
                        chk($sformatf("m%0d_ack_owner", m), {31'h0, grant_o[m]}, 32'h1);
                        take_resp(m, 1'b0, (m == 0) ? rdat0 : rdat1);
                    end
                    if (err_v[m]) begin
                        chk($sformatf("m%0d_err_after_grant", m), 32'(cnt[m]), 32'(TO));
                        take_resp(m, 1'b1, 32'h0);
                    end
                end
                if (grant_o != 2'b00) begin
                    o = grant_o[1] ? 1 : 0;
                    chk("route_adr", {2'b00, s_adr}, {2'b00, m_adr[o]});
                    chk("route_dat", s_dat, m_dat[o]);
                    chk("route_ctl", {25'h0, s_cyc, s_stb, s_we, s_sel},
                        {25'h0, m_cyc[o], m_stb[o], m_we[o], m_sel[o]});
                end else begin
                    chk("idle_bus", {s_cyc, s_stb, s_adr}, 32'h0);
                end
                if (have_prev) begin
                    if (prev_g == 2'b00) begin
                        if (prev_req == 2'b11)      exp_g = last_w ? 2'b01 : 2'b10;
                        else                        exp_g = prev_req;
                        chk("grant_pred", {30'h0, grant_o}, {30'h0, exp_g});
                        if (exp_g != 2'b00) last_w = exp_g[1];
                    end else if (grant_o != 2'b00) begin
                        chk("grant_stable", {30'h0, grant_o}, {30'h0, prev_g});
                    end
                end
                for (int m = 0; m < 2; m++)
                    if (grant_o[m]) cnt[m] = prev_g[m] ? cnt[m] + 1 : 1;
                prev_g    = grant_o;
                prev_req  = {m_cyc[1] & m_stb[1], m_cyc[0] & m_stb[0]};
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    // Directed scenarios, then randomised traffic from both masters.
    initial begin
        rst_n = 1'b0;
        slave_dead = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = 30'h0; m_dat[m] = 32'h0; m_we[m] = 1'b0;
            m_sel[m] = 4'h0;  m_stb[m] = 1'b0;  m_cyc[m] = 1'b0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        #1;
        chk("reset_outputs", {19'h0, grant_o, ack_v, err_v, s_cyc, s_stb, s_we, s_sel}, 32'h0);
        chk("reset_adr", {2'b00, s_adr}, 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        do_xfer(0, 1'b0, 30'h10, 32'h0, 4'hF, 1'b0, 3);

        fork
            for (int k = 0; k < 4; k++) do_xfer(0, 1'($urandom), rnd_adr(0), $urandom, 4'hF, 1'b0, 0);
            for (int k = 0; k < 4; k++) do_xfer(1, 1'($urandom), rnd_adr(1), $urandom, 4'hF, 1'b0, 0);
        join
        tick(2);

        do_xfer(1, 1'b1, 30'h23, 32'h12345678, 4'b0110, 1'b0, 3);
        do_xfer(1, 1'b0, 30'h23, 32'h0, 4'hF, 1'b0, 3);
        tick(1);

        slave_dead = 1'b1;
        do_xfer(0, 1'b0, 30'h05, 32'h0, 4'hF, 1'b1, 0);
        slave_dead = 1'b0;
        tick(2);
        do_xfer(1, 1'b0, 30'h2A, 32'h0, 4'hF, 1'b0, 3);
        tick(1);

        slave_dead = 1'b1;
        m_adr[0] = 30'h07; m_we[0] = 1'b0; m_sel[0] = 4'hF;
        m_cyc[0] = 1'b1;   m_stb[0] = 1'b1;
        fork
            begin
                tick(1);
                do_xfer(1, 1'b0, 30'h31, 32'h0, 4'hF, 1'b0, 0);
            end
            begin
                tick(3);
                m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
                slave_dead = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("abort_back_to_idle", {30'h0, grant_o}, 32'h0);
            end
        join
        tick(2);

        m_adr[0] = 30'h11; m_we[0] = 1'b0; m_sel[0] = 4'hF;
        m_cyc[0] = 1'b1;   m_stb[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midcycle_reset_outputs", {19'h0, grant_o, ack_v, err_v, s_cyc, s_stb, s_we, s_sel}, 32'h0);
        chk("midcycle_reset_rdata", rdat0 | rdat1 | s_dat, 32'h0);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        fork
            do_xfer(0, 1'b0, 30'h12, 32'h0, 4'hF, 1'b0, 3);
            do_xfer(1, 1'b0, 30'h32, 32'h0, 4'hF, 1'b0, 0);
        join

        fork
            for (int k = 0; k < 30; k++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                if (gap > 0) tick(gap);
                do_xfer(0, 1'($urandom), rnd_adr(0), $urandom, 4'($urandom), 1'b0, 0);
            end
            for (int k = 0; k < 30; k++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                if (gap > 0) tick(gap);
                do_xfer(1, 1'($urandom), rnd_adr(1), $urandom, 4'($urandom), 1'b0, 0);
            end
        join
        tick(5);
        chk("m0_outstanding", 32'(exp0_q.size()), 32'h0);
        chk("m1_outstanding", 32'(exp1_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
